// File: rtl/alu_mult_seq.sv
// Radix-2 shift-add 16x16->32 multiply sequencer that borrows the shared ALU.
// Optional signed support is enabled by defining SIGNED_MULT_EN.
module alu_mult_seq #(
  parameter logic [2:0] OP_ADD = 3'b100,
  parameter int         CNT_W  = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        signed_op,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_cin,
  output logic        alu_inva,
  output logic        alu_invb,
  output logic        alu_sign,
  input  logic [15:0] alu_out,
  input  logic        alu_ofl
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(15);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic [15:0]      mcand;
  logic [15:0]      hi;
  logic [15:0]      lo;
  logic [CNT_W-1:0] cnt;
  logic             sgn;
  logic             sgn_req;
  logic             ins;
  logic             last;

`ifdef SIGNED_MULT_EN
  assign sgn_req = signed_op;
`else
  assign sgn_req = signed_op & 1'b0;
`endif

  assign last = (cnt == CNT_LAST);

  // With a signed sum the true 17th bit is the result sign corrected by overflow.
  always_comb begin
    ins = alu_ofl;
    if (sgn) begin
      ins = alu_out[15] ^ alu_ofl;
    end else begin
      ins = alu_ofl;
    end
  end

  // ALU operand/control drive; the final signed step subtracts (MSB has negative weight).
  always_comb begin
    alu_a    = 16'h0000;
    alu_b    = 16'h0000;
    alu_op   = OP_ADD;
    alu_cin  = 1'b0;
    alu_inva = 1'b0;
    alu_invb = 1'b0;
    alu_sign = 1'b0;
    if (state == S_RUN) begin
      alu_a    = hi;
      alu_sign = sgn;
      if (lo[0]) begin
        alu_b = mcand;
        if (sgn && last) begin
          alu_invb = 1'b1;
          alu_cin  = 1'b1;
        end else begin
          alu_invb = 1'b0;
          alu_cin  = 1'b0;
        end
      end else begin
        alu_b = 16'h0000;
      end
    end else begin
      alu_a = 16'h0000;
    end
  end

  // Sequencer state, datapath registers and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= 32'h0000_0000;
      hi      <= 16'h0000;
      lo      <= 16'h0000;
      mcand   <= 16'h0000;
      cnt     <= '0;
      sgn     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= a;
            lo    <= b;
            hi    <= 16'h0000;
            cnt   <= '0;
            sgn   <= sgn_req;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          {hi, lo} <= {ins, alu_out, lo[15:1]};
          cnt      <= cnt + CNT_ONE;
          if (last) begin
            product <= {ins, alu_out, lo[15:1]};
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mult_seq.sv
// Directed self-checking bench for alu_mult_seq with a behavioural model of the shared ALU.
module tb_alu_mult_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        signed_op = 1'b0;
  logic        busy, done;
  logic [31:0] product;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_op;
  logic        alu_cin, alu_inva, alu_invb, alu_sign, alu_ofl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_mult_seq dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .signed_op(signed_op),
    .busy(busy), .done(done), .product(product),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_inva(alu_inva), .alu_invb(alu_invb), .alu_sign(alu_sign),
    .alu_out(alu_out), .alu_ofl(alu_ofl)
  );

  // External ALU: add with optional operand inversion; Ofl is carry when unsigned.
  logic [15:0] opa, opb;
  logic [16:0] sum;
  always_comb begin
    opa     = alu_inva ? ~alu_a : alu_a;
    opb     = alu_invb ? ~alu_b : alu_b;
    sum     = {1'b0, opa} + {1'b0, opb} + {16'h0000, alu_cin};
    alu_out = sum[15:0];
    alu_ofl = alu_sign ? ((opa[15] == opb[15]) && (sum[15] != opa[15])) : sum[16];
  end

  task automatic do_mult(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                         output logic [31:0] prod, output int nbusy, output int lat);
    @(negedge clk);
    a = ta; b = tb; signed_op = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        lat = k;
        break;
      end
    end
    prod = product;
  endtask

  task automatic check_idle_alu(input string tag);
    checks++;
    if ({alu_a, alu_b, alu_op, alu_cin, alu_inva, alu_invb, alu_sign} !== {16'h0000, 16'h0000, 3'b100, 4'b0000}) begin
      errors++;
      $display("FAIL %s idle alu: a=%h b=%h op=%b cin/inva/invb/sign=%b%b%b%b expected 0000 0000 100 0000",
               tag, alu_a, alu_b, alu_op, alu_cin, alu_inva, alu_invb, alu_sign);
    end
  endtask

  task automatic check_mult(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                            input logic ts, input logic [31:0] exp);
    logic [31:0] p;
    int nb, lat;
    do_mult(ta, tb, ts, p, nb, lat);
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("FAIL %s latency: got %0d expected 17 (0 = timeout)", tag, lat);
    end
    checks++;
    if (p !== exp) begin
      errors++;
      $display("FAIL %s product: got %h expected %h", tag, p, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if ({busy, done, product} !== {1'b0, 1'b0, 32'h0000_0000}) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b product=%h expected 0 0 00000000", busy, done, product);
    end
    check_idle_alu("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] p;
    int nb, lat;
    do_mult(16'd3, 16'd5, 1'b0, p, nb, lat);
    checks++;
    if (nb !== 16) begin
      errors++;
      $display("FAIL basic busy cycles: got %0d expected 16", nb);
    end
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("FAIL basic latency: got %0d expected 17", lat);
    end
    checks++;
    if (p !== 32'h0000_000F) begin
      errors++;
      $display("FAIL basic product: got %h expected 0000000f", p);
    end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++;
      $display("FAIL basic done width: done=%b busy=%b expected 0 0", done, busy);
    end
    check_idle_alu("after op");
  endtask

  task automatic test_unsigned();
    check_mult("ffff*ffff", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
    check_mult("1234*5678", 16'h1234, 16'h5678, 1'b0, 32'h0626_0060);
    check_mult("8000*8000u", 16'h8000, 16'h8000, 1'b0, 32'h4000_0000);
  endtask

  task automatic test_signed();
`ifdef SIGNED_MULT_EN
    check_mult("-2*3", 16'hFFFE, 16'h0003, 1'b1, 32'hFFFF_FFFA);
    check_mult("8000*8000s", 16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
    check_mult("3*-2", 16'h0003, 16'hFFFE, 1'b1, 32'hFFFF_FFFA);
    check_mult("-1*-1", 16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001);
`else
    check_mult("signed ignored fffe*3", 16'hFFFE, 16'h0003, 1'b1, 32'h0002_FFFA);
    check_mult("signed ignored ffff*ffff", 16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE_0001);
`endif
  endtask

  task automatic test_ignore_start();
    int ndone = 0;
    @(negedge clk);
    a = 16'd3; b = 16'd5; signed_op = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 16'h1234; b = 16'h5678;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (done) begin
        ndone++;
        start = 1'b0;
      end
      if (k == 20) start = 1'b0;
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL ignore start done count: got %0d expected 1", ndone);
    end
    checks++;
    if (product !== 32'h0000_000F) begin
      errors++;
      $display("FAIL ignore start product: got %h expected 0000000f", product);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore start busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int ndone = 0;
    @(negedge clk);
    a = 16'h1234; b = 16'h0005; signed_op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, product} !== {1'b0, 1'b0, 32'h0000_0000}) begin
      errors++;
      $display("FAIL mid reset: busy=%b done=%b product=%h expected 0 0 00000000", busy, done, product);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL mid reset spurious done: got %0d expected 0", ndone);
    end
    check_mult("7*9 after reset", 16'd7, 16'd9, 1'b0, 32'h0000_003F);
  endtask

  task automatic test_zero();
    check_mult("0*1234", 16'h0000, 16'h1234, 1'b0, 32'h0000_0000);
    check_mult("1234*0", 16'h1234, 16'h0000, 1'b1, 32'h0000_0000);
    @(negedge clk);
    check_idle_alu("after zero");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_unsigned();
    test_signed();
    test_ignore_start();
    test_reset_mid_run();
    test_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
